// File: rtl/instr_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | instr_fetch_unit: multicycle fetch stage owning PC, OldPC and the IR,      |
// | single-word req/gnt/rvalid fetch. Optional macro FETCH_MISALIGN_CHECK_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package instr_fetch_pkg;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_FENCE  = 7'h0F,
    OP_I      = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_R      = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_e;
endpackage

module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_start_i,
  input  logic        pc_we_i,
  input  logic [31:0] pc_next_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] old_pc_o,
  output logic [31:0] instr_o,
  output opcode_e     opcode_o,
  output logic        instr_valid_o,
  output logic        busy_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_old_pc;
  logic [31:0] r_instr;
  logic [31:0] r_fetch_addr;
  logic        r_req;
  logic        r_instr_valid;
  logic        r_fault;
  logic [31:0] w_sel_addr;
  logic        w_misalign;
  logic        w_start_ok;
  logic        w_done;

  // A same-cycle PC write redirects the fetch it accompanies.
  assign w_sel_addr = pc_we_i ? pc_next_i : r_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign = |w_sel_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_start_i && !w_misalign) begin
          w_state_next = S_REQ;
          w_start_ok   = 1'b1;
        end
      end
      S_REQ: begin
        if (imem_gnt_i) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc          <= RESET_PC;
      r_old_pc      <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_fetch_addr  <= RESET_PC;
      r_req         <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_instr_valid <= w_done;
      r_fault       <= (r_state == S_IDLE) && fetch_start_i && w_misalign;
      if ((r_state == S_IDLE) && pc_we_i) r_pc <= pc_next_i;
      if (w_start_ok) begin
        r_fetch_addr <= w_sel_addr;
        r_req        <= 1'b1;
      end
      if ((r_state == S_REQ) && imem_gnt_i) r_req <= 1'b0;
      // Completion only happens in WAIT, so it never races the IDLE PC write.
      if (w_done) begin
        r_instr  <= imem_rdata_i;
        r_old_pc <= r_fetch_addr;
        r_pc     <= r_fetch_addr + 32'd4;
      end
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_fetch_addr;
  assign pc_o          = r_pc;
  assign old_pc_o      = r_old_pc;
  assign instr_o       = r_instr;
  assign opcode_o      = opcode_e'(r_instr[6:0]);
  assign instr_valid_o = r_instr_valid;
  assign busy_o        = (r_state != S_IDLE);
  assign fault_o       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_instr_fetch_unit: directed, scoreboard-based bench for instr_fetch_unit |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;
  import instr_fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_start_i;
  logic        pc_we_i;
  logic [31:0] pc_next_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] old_pc_o;
  logic [31:0] instr_o;
  opcode_e     opcode_o;
  logic        instr_valid_o;
  logic        busy_o;
  logic        fault_o;

  instr_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_start_i (fetch_start_i),
    .pc_we_i       (pc_we_i),
    .pc_next_i     (pc_next_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .old_pc_o      (old_pc_o),
    .instr_o       (instr_o),
    .opcode_o      (opcode_o),
    .instr_valid_o (instr_valid_o),
    .busy_o        (busy_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] pc;
    logic [6:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc = 32'h0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full fetch: gd cycles of withheld gnt, rd cycles of withheld rvalid.
  task automatic fetch(input logic we, input logic [31:0] nxt, input int gd, input int rd,
                       input logic [31:0] data, input logic [6:0] op, input logic junk_wait);
    logic [31:0] addr;
    int          edges;
    logic        seen;
    exp_t        e;
    addr = we ? nxt : exp_pc;
    fetch_start_i = 1'b1; pc_we_i = we; pc_next_i = nxt;
    tick(); edges = 1;
    fetch_start_i = 1'b0; pc_we_i = 1'b0;
    chk("req_hi", {31'b0, imem_req_o}, 32'd1);
    chk("req_addr", imem_addr_o, addr);
    chk("busy_req", {31'b0, busy_o}, 32'd1);
    for (int i = 0; i < gd; i++) begin
      fetch_start_i = 1'b1; pc_we_i = 1'b1; pc_next_i = 32'h0000_0055;
      tick(); edges++;
      chk("addr_stable", imem_addr_o, addr);
      chk("req_held", {31'b0, imem_req_o}, 32'd1);
      chk("busy_held", {31'b0, busy_o}, 32'd1);
    end
    fetch_start_i = 1'b0; pc_we_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick(); edges++;
    imem_gnt_i = 1'b0;
    chk("req_lo_wait", {31'b0, imem_req_o}, 32'd0);
    chk("busy_wait", {31'b0, busy_o}, 32'd1);
    for (int i = 0; i < rd; i++) begin
      if (junk_wait) begin pc_we_i = 1'b1; pc_next_i = 32'hDEAD_0000; end
      tick(); edges++;
      chk("no_early_valid", {31'b0, instr_valid_o}, 32'd0);
    end
    pc_we_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = data;
    e = '{instr: data, old_pc: addr, pc: addr + 32'd4, op: op};
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(); edges++;
      imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      seen = instr_valid_o;
    end
    chk("valid_seen", {31'b0, seen}, 32'd1);
    chk("latency", edges, 3 + gd + rd);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        chk("instr", instr_o, e.instr);
        chk("old_pc", old_pc_o, e.old_pc);
        chk("pc", pc_o, e.pc);
        chk("opcode", {25'b0, opcode_o}, {25'b0, e.op});
      end
    end
    exp_pc = addr + 32'd4;
    tick();
    chk("valid_pulse", {31'b0, instr_valid_o}, 32'd0);
    chk("busy_idle", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_old_pc"}, old_pc_o, 32'h0);
    chk({tag, "_instr"}, instr_o, 32'h0000_0013);
    chk({tag, "_opcode"}, {25'b0, opcode_o}, 32'h13);
    chk({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_fault"}, {31'b0, fault_o}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; fetch_start_i = 1'b0; pc_we_i = 1'b0; pc_next_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    tick(); tick();
    chk_reset_vals("rst");
    rst_ni = 1'b1;

    // Stale response in IDLE must be dropped.
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hFFFF_FFFF;
    tick();
    imem_rvalid_i = 1'b0;
    chk("stale_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("stale_instr", instr_o, 32'h0000_0013);

    fetch(1'b0, 32'h0, 0, 0, 32'h0050_0093, 7'h13, 1'b0);
    fetch(1'b0, 32'h0, 3, 2, 32'h00A0_0113, 7'h13, 1'b0);
    fetch(1'b1, 32'h0000_0100, 0, 1, 32'h0020_81B3, 7'h33, 1'b1);

    // PC write without fetch, then wrap on completion.
    pc_we_i = 1'b1; pc_next_i = 32'hFFFF_FFFC;
    tick();
    pc_we_i = 1'b0;
    chk("pcwe_pc", pc_o, 32'hFFFF_FFFC);
    chk("pcwe_req", {31'b0, imem_req_o}, 32'd0);
    chk("pcwe_busy", {31'b0, busy_o}, 32'd0);
    exp_pc = 32'hFFFF_FFFC;
    fetch(1'b0, 32'h0, 1, 0, 32'h0000_006F, 7'h6F, 1'b0);
    chk("wrap_pc", pc_o, 32'h0);

    // Reset asserted while waiting for read data.
    fetch_start_i = 1'b1; pc_we_i = 1'b1; pc_next_i = 32'h0000_0200;
    tick();
    fetch_start_i = 1'b0; pc_we_i = 1'b0; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    chk("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    tick();
    imem_rvalid_i = 1'b0;
    chk_reset_vals("postrst");
    exp_pc = 32'h0;

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_start_i = 1'b1; pc_we_i = 1'b1; pc_next_i = 32'h0000_0102;
    tick();
    fetch_start_i = 1'b0; pc_we_i = 1'b0;
    chk("mis_req", {31'b0, imem_req_o}, 32'd0);
    chk("mis_busy", {31'b0, busy_o}, 32'd0);
    chk("mis_fault", {31'b0, fault_o}, 32'd1);
    chk("mis_pc", pc_o, 32'h0000_0102);
    tick();
    chk("mis_fault_pulse", {31'b0, fault_o}, 32'd0);
    chk("mis_instr", instr_o, 32'h0000_0013);
    chk("mis_old_pc", old_pc_o, 32'h0);
`else
    fetch(1'b1, 32'h0000_0102, 0, 0, 32'h0000_0037, 7'h37, 1'b0);
    chk("mis_fault_lo", {31'b0, fault_o}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the multicycle RISC-V core: it owns the PC, OldPC and instruction registers. On request from the main control FSM it performs a single word read over a req/gnt/rvalid instruction-memory handshake and latches the returned word. The latched instruction's opcode field drives the instruction decoder and the control FSM for the rest of the instruction's cycles.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0013, instruction register value after reset (addi x0,x0,0)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- fetch_start_i  in  1  control FSM requests a fetch at the current PC
- pc_we_i  in  1  PC write enable (branch/jump/PC update from datapath)
- pc_next_i  in  32  value written to PC when pc_we_i accepted
- imem_req_o  out  1  memory request
- imem_addr_o  out  32  request address, byte address
- imem_gnt_i  in  1  memory accepted request
- imem_rvalid_i  in  1  read data valid
- imem_rdata_i  in  32  read data
- pc_o  out  32  current PC register
- old_pc_o  out  32  PC of the latched instruction
- instr_o  out  32  instruction register
- opcode_o  out  opcode_e  instr_o[6:0] cast to opcode_e (combinational from IR)
- instr_valid_o  out  1  one-cycle pulse: IR updated this cycle
- busy_o  out  1  high in any state other than IDLE
- fault_o  out  1  one-cycle pulse: misaligned fetch rejected (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: fetch_start_i=1 -> REQ; fetch address = pc_next_i if pc_we_i=1 same cycle, else PC. Address captured into an internal fetch-address register.
- REQ: imem_req_o=1, imem_addr_o=fetch-address register, held stable until imem_gnt_i=1 -> WAIT.
- WAIT: imem_req_o=0. On imem_rvalid_i=1: IR<=imem_rdata_i, old_pc<=fetch address, PC<=fetch address+4 (mod 2^32), instr_valid_o<=1, -> IDLE.
- rvalid in REQ (same cycle as gnt) is ignored; memory must return data no earlier than the cycle after gnt.
- pc_we_i accepted only in IDLE; ignored in REQ/WAIT. pc_we_i without fetch_start_i: PC<=pc_next_i, no fetch.
- fetch_start_i ignored while busy_o=1.
- imem_rvalid_i in IDLE is ignored (covers stale responses after reset).
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset values: state IDLE, pc_o=RESET_PC, old_pc_o=RESET_PC, instr_o=NOP_INSTR (opcode_o=OP_I), imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, busy_o=0, fault_o=0.
- All outputs registered except opcode_o and busy_o (decoded from state).
- fetch_start_i at edge N -> imem_req_o high from cycle N+1; gnt in cycle N+1 -> WAIT in N+2; rvalid in N+2 -> instr_o, pc_o, old_pc_o updated and instr_valid_o high in N+3. Minimum fetch latency 3 cycles; each extra gnt/rvalid wait cycle adds one.
- rst_ni asserted mid-fetch: immediate return to reset values; in-flight request abandoned.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: fetch whose selected address has [1:0]!=2'b00 issues no request, stays IDLE, pulses fault_o next cycle; PC/IR/old_pc unchanged (PC still takes pc_next_i if pc_we_i was set).
- Not defined: no check; address issued as-is, fault_o tied 0.

## Test plan
- Reset then fetch_start_i, gnt immediate, rvalid next cycle with 32'h0050_0093 -> instr_o=32'h0050_0093, opcode_o=OP_I, old_pc_o=0, pc_o=4, instr_valid_o single pulse 3 cycles after start.
- gnt delayed 3 cycles, rvalid delayed 2 -> imem_addr_o stable throughout REQ, instr_valid_o at cycle 8, busy_o high cycles 1-7.
- pc_we_i=1, pc_next_i=32'h0000_0100 with fetch_start_i same cycle -> imem_addr_o=32'h100, after fetch pc_o=32'h104, old_pc_o=32'h100; pc_we_i during WAIT -> ignored.
- PC=32'hFFFF_FFFC fetch -> pc_o=0 after completion.
- rst_ni low during WAIT, then rvalid arrives after release -> all outputs at reset values, no instr_valid_o.
- With FETCH_MISALIGN_CHECK_EN, pc_next_i=32'h0000_0102 + fetch_start_i -> no imem_req_o, fault_o pulse, busy_o stays 0; without macro -> request to 32'h102.
